demux_six_seq: RTL and testbench

DEMUX_SIX_SEQ -- requirements
Module: demux_six_seq

---
 rtl/demux_six_seq_pkg.sv | 32 +++
 rtl/demux_six_seq_dec3to6.sv | 26 ++
 rtl/demux_six_seq.sv | 148 ++++++++++++++
 tb/tb_demux_six_seq.sv | 206 ++++++++++++++++++++
 4 files changed

// File: rtl/demux_six_seq_pkg.sv
// Shared definitions for the six-channel frame demultiplexer: channel
// geometry, frame FSM states, slot index type and slot wrap helper.
package demux_six_seq_pkg;

  localparam int W   = 3;
  localparam int NCH = 6;

  // Frame progress: nothing written, partially written, just completed.
  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    FILL  = 2'd1,
    DONE  = 2'd2
  } state_t;

  // Channel / slot index; codes 6 and 7 are not real channels.
  typedef logic [2:0] slot_t;

  localparam logic [5:0] MASK_FULL = 6'b111111;
  localparam slot_t      SLOT_LAST = 3'd5;

  // Sequential slot advance: 0,1,2,3,4,5,0,...
  function automatic slot_t next_slot(input slot_t s);
    slot_t n;
    if (s == SLOT_LAST) begin
      n = 3'd0;
    end else begin
      n = s + 3'd1;
    end
    return n;
  endfunction

endpackage

// File: rtl/demux_six_seq_dec3to6.sv
// 3-to-6 one-hot decoder. Codes 6 and 7 give an all-zero one-hot vector
// and raise o_invalid so the caller can reject the write.
module dec3to6
  import demux_six_seq_pkg::*;
(
  input  slot_t      i_code,
  output logic [5:0] o_onehot,
  output logic       o_invalid
);

  // Pure combinational decode of the channel code.
  always_comb begin
    o_onehot  = 6'b000000;
    o_invalid = 1'b0;
    case (i_code)
      3'd0:    o_onehot = 6'b000001;
      3'd1:    o_onehot = 6'b000010;
      3'd2:    o_onehot = 6'b000100;
      3'd3:    o_onehot = 6'b001000;
      3'd4:    o_onehot = 6'b010000;
      3'd5:    o_onehot = 6'b100000;
      default: o_invalid = 1'b1;
    endcase
  end

endmodule

// File: rtl/demux_six_seq.sv
// Six-channel demultiplexer with addressed and sequential (auto-slot)
// write modes. Tracks which channels were written in the current frame
// and pulses frame_done when all six have been written.
module demux_six_seq #(
  parameter int W   = demux_six_seq_pkg::W,
  parameter int NCH = demux_six_seq_pkg::NCH
) (
  input  logic         clk,
  input  logic         resetn,
  input  logic         in_valid,
  input  logic [W-1:0] in_data,
  input  logic [2:0]   in_sel,
  input  logic         mode,
  output logic [W-1:0] u,
  output logic [W-1:0] v,
  output logic [W-1:0] w,
  output logic [W-1:0] x,
  output logic [W-1:0] y,
  output logic [W-1:0] z,
  output logic [5:0]   wr_mask,
  output logic         frame_done,
  output logic         sel_err
);

  import demux_six_seq_pkg::*;

  // Registered state
  logic [W-1:0] r_ch [NCH];
  logic [5:0]   r_mask;
  slot_t        r_slot;
  state_t       r_state;
  logic         r_mode;
  logic         r_done;
  logic         r_sel_err;

  // Combinational next-state helpers
  logic         w_mode_chg;
  logic [5:0]   w_base_mask;
  state_t       w_base_state;
  slot_t        w_base_slot;
  slot_t        w_idx;
  logic [5:0]   w_onehot;
  logic         w_invalid;
  logic         w_write;
  logic [5:0]   w_new_mask;

  // One decoder serves both the addressed select and the slot counter.
  dec3to6 u_dec (
    .i_code    (w_idx),
    .o_onehot  (w_onehot),
    .o_invalid (w_invalid)
  );

  // Frame bookkeeping seen by this cycle's write: a mode change or the
  // cycle after completion starts a fresh frame before the write lands.
  always_comb begin
    w_mode_chg   = (mode != r_mode);
    w_base_mask  = r_mask;
    w_base_state = r_state;
    w_base_slot  = r_slot;
    if (w_mode_chg || (r_state == DONE)) begin
      w_base_mask  = 6'b000000;
      w_base_state = EMPTY;
    end else begin
      w_base_mask  = r_mask;
      w_base_state = r_state;
    end
    if (w_mode_chg) begin
      w_base_slot = 3'd0;
    end else begin
      w_base_slot = r_slot;
    end
    if (mode) begin
      w_idx = w_base_slot;
    end else begin
      w_idx = in_sel;
    end
    w_write = in_valid & ~w_invalid;
    if (w_write) begin
      w_new_mask = w_base_mask | w_onehot;
    end else begin
      w_new_mask = w_base_mask;
    end
  end

  // Channel registers, slot counter, frame FSM and status pulses.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      for (int k = 0; k < NCH; k++) begin
        r_ch[k] <= '0;
      end
      r_mask    <= 6'b000000;
      r_slot    <= 3'd0;
      r_state   <= EMPTY;
      r_mode    <= 1'b0;
      r_done    <= 1'b0;
      r_sel_err <= 1'b0;
    end else begin
      r_mode    <= mode;
      r_sel_err <= in_valid & w_invalid;
      for (int k = 0; k < NCH; k++) begin
        if (w_write && w_onehot[k]) begin
          r_ch[k] <= in_data;
        end else begin
          r_ch[k] <= r_ch[k];
        end
      end
      if (mode && w_write) begin
        r_slot <= next_slot(w_base_slot);
      end else begin
        r_slot <= w_base_slot;
      end
      case (w_base_state)
        EMPTY, FILL: begin
          if (w_write && (w_new_mask == MASK_FULL)) begin
            r_state <= DONE;
            r_mask  <= MASK_FULL;
            r_done  <= 1'b1;
          end else if (w_write) begin
            r_state <= FILL;
            r_mask  <= w_new_mask;
            r_done  <= 1'b0;
          end else begin
            r_state <= w_base_state;
            r_mask  <= w_base_mask;
            r_done  <= 1'b0;
          end
        end
        default: begin
          r_state <= EMPTY;
          r_mask  <= 6'b000000;
          r_done  <= 1'b0;
        end
      endcase
    end
  end

  assign u          = r_ch[0];
  assign v          = r_ch[1];
  assign w          = r_ch[2];
  assign x          = r_ch[3];
  assign y          = r_ch[4];
  assign z          = r_ch[5];
  assign wr_mask    = r_mask;
  assign frame_done = r_done;
  assign sel_err    = r_sel_err;

endmodule

// File: tb/tb_demux_six_seq.sv
// Table-driven bench for demux_six_seq with a scoreboard queue of
// expected outputs, plus a hand-written frame-pulse sequence.
module tb_demux_six_seq;

  localparam int TW = 3;

  typedef struct {
    logic            rstn;
    logic            valid;
    logic            mode;
    logic [2:0]      sel;
    logic [TW-1:0]   data;
    logic [6*TW-1:0] chans;
    logic [5:0]      mask;
    logic            done;
    logic            err;
  } vec_t;

  typedef struct {
    logic [6*TW-1:0] chans;
    logic [5:0]      mask;
    logic            done;
    logic            err;
  } exp_t;

  logic          clk;
  logic          resetn;
  logic          in_valid;
  logic [TW-1:0] in_data;
  logic [2:0]    in_sel;
  logic          mode;
  logic [TW-1:0] u, v, w, x, y, z;
  logic [5:0]    wr_mask;
  logic          frame_done;
  logic          sel_err;

  int   n_checks;
  int   n_fail;
  vec_t vecs[$];
  exp_t sb_q[$];

  demux_six_seq #(.W(TW), .NCH(6)) dut (
    .clk        (clk),
    .resetn     (resetn),
    .in_valid   (in_valid),
    .in_data    (in_data),
    .in_sel     (in_sel),
    .mode       (mode),
    .u          (u),
    .v          (v),
    .w          (w),
    .x          (x),
    .y          (y),
    .z          (z),
    .wr_mask    (wr_mask),
    .frame_done (frame_done),
    .sel_err    (sel_err)
  );

  always #5 clk = ~clk;

  function automatic vec_t mk(input bit rs, input bit vl, input bit md,
                              input int sl, input int dt,
                              input int cu, input int cv, input int cw,
                              input int cx, input int cy, input int cz,
                              input logic [5:0] mk_mask, input bit dn, input bit er);
    vec_t r;
    r.rstn  = rs;
    r.valid = vl;
    r.mode  = md;
    r.sel   = 3'(sl);
    r.data  = TW'(dt);
    r.chans = {TW'(cz), TW'(cy), TW'(cx), TW'(cw), TW'(cv), TW'(cu)};
    r.mask  = mk_mask;
    r.done  = dn;
    r.err   = er;
    return r;
  endfunction

  task automatic check(input string name, input int idx,
                       input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s vec %0d: got %h expected %h", name, idx, got, exp);
    end
  endtask

  // Drive one vector, queue its expectation, compare after the edge.
  task automatic step(input vec_t vc, input int idx);
    exp_t e;
    exp_t g;
    @(negedge clk);
    resetn   = vc.rstn;
    in_valid = vc.valid;
    mode     = vc.mode;
    in_sel   = vc.sel;
    in_data  = vc.data;
    e.chans  = vc.chans;
    e.mask   = vc.mask;
    e.done   = vc.done;
    e.err    = vc.err;
    sb_q.push_back(e);
    @(posedge clk);
    #1;
    g = sb_q.pop_front();
    check("channels", idx, 32'({z, y, x, w, v, u}), 32'(g.chans));
    check("wr_mask", idx, 32'(wr_mask), 32'(g.mask));
    check("frame_done", idx, 32'(frame_done), 32'(g.done));
    check("sel_err", idx, 32'(sel_err), 32'(g.err));
  endtask

  initial begin
    int pulses;
    int first_pulse;
    clk = 1'b0; resetn = 1'b0; in_valid = 1'b0; in_data = '0;
    in_sel = 3'd0; mode = 1'b0;
    n_checks = 0; n_fail = 0;

    // reset, and reset overriding a write
    vecs.push_back(mk(0,0,0,0,0, 0,0,0,0,0,0, 6'b000000,0,0));
    vecs.push_back(mk(0,1,0,0,5, 0,0,0,0,0,0, 6'b000000,0,0));
    // addressed frame sel 0..5, data 1..6
    vecs.push_back(mk(1,1,0,0,1, 1,0,0,0,0,0, 6'b000001,0,0));
    vecs.push_back(mk(1,1,0,1,2, 1,2,0,0,0,0, 6'b000011,0,0));
    vecs.push_back(mk(1,1,0,2,3, 1,2,3,0,0,0, 6'b000111,0,0));
    vecs.push_back(mk(1,1,0,3,4, 1,2,3,4,0,0, 6'b001111,0,0));
    vecs.push_back(mk(1,1,0,4,5, 1,2,3,4,5,0, 6'b011111,0,0));
    vecs.push_back(mk(1,1,0,5,6, 1,2,3,4,5,6, 6'b111111,1,0));
    vecs.push_back(mk(1,0,0,0,0, 1,2,3,4,5,6, 6'b000000,0,0));
    // invalid selects 6 and 7, rewrite of a set channel
    vecs.push_back(mk(1,1,0,6,5, 1,2,3,4,5,6, 6'b000000,0,1));
    vecs.push_back(mk(1,0,0,0,0, 1,2,3,4,5,6, 6'b000000,0,0));
    vecs.push_back(mk(1,1,0,0,7, 7,2,3,4,5,6, 6'b000001,0,0));
    vecs.push_back(mk(1,1,0,7,2, 7,2,3,4,5,6, 6'b000001,0,1));
    vecs.push_back(mk(1,1,0,0,0, 0,2,3,4,5,6, 6'b000001,0,0));
    // sequential 7..0 with wrap
    vecs.push_back(mk(1,1,1,0,7, 7,2,3,4,5,6, 6'b000001,0,0));
    vecs.push_back(mk(1,1,1,0,6, 7,6,3,4,5,6, 6'b000011,0,0));
    vecs.push_back(mk(1,1,1,0,5, 7,6,5,4,5,6, 6'b000111,0,0));
    vecs.push_back(mk(1,1,1,0,4, 7,6,5,4,5,6, 6'b001111,0,0));
    vecs.push_back(mk(1,1,1,0,3, 7,6,5,4,3,6, 6'b011111,0,0));
    vecs.push_back(mk(1,1,1,0,2, 7,6,5,4,3,2, 6'b111111,1,0));
    vecs.push_back(mk(1,1,1,0,1, 1,6,5,4,3,2, 6'b000001,0,0));
    vecs.push_back(mk(1,1,1,0,0, 1,0,5,4,3,2, 6'b000011,0,0));
    vecs.push_back(mk(1,0,1,0,0, 1,0,5,4,3,2, 6'b000011,0,0));
    // three sequential words then a mode flip with an addressed write
    vecs.push_back(mk(1,1,1,0,1, 1,0,1,4,3,2, 6'b000111,0,0));
    vecs.push_back(mk(1,1,1,0,2, 1,0,1,2,3,2, 6'b001111,0,0));
    vecs.push_back(mk(1,1,1,0,3, 1,0,1,2,3,2, 6'b011111,0,0));
    vecs.push_back(mk(1,1,0,4,7, 1,0,1,2,7,2, 6'b010000,0,0));
    // four sequential words, reset with valid high, then restart on u
    vecs.push_back(mk(1,1,1,0,4, 4,0,1,2,7,2, 6'b000001,0,0));
    vecs.push_back(mk(1,1,1,0,5, 4,5,1,2,7,2, 6'b000011,0,0));
    vecs.push_back(mk(1,1,1,0,6, 4,5,6,2,7,2, 6'b000111,0,0));
    vecs.push_back(mk(1,1,1,0,7, 4,5,6,7,7,2, 6'b001111,0,0));
    vecs.push_back(mk(0,1,1,0,3, 0,0,0,0,0,0, 6'b000000,0,0));
    vecs.push_back(mk(1,1,1,0,2, 2,0,0,0,0,0, 6'b000001,0,0));
    // addressed frame then a write landing in the DONE cycle
    vecs.push_back(mk(1,1,0,0,1, 1,0,0,0,0,0, 6'b000001,0,0));
    vecs.push_back(mk(1,1,0,1,1, 1,1,0,0,0,0, 6'b000011,0,0));
    vecs.push_back(mk(1,1,0,2,1, 1,1,1,0,0,0, 6'b000111,0,0));
    vecs.push_back(mk(1,1,0,3,1, 1,1,1,1,0,0, 6'b001111,0,0));
    vecs.push_back(mk(1,1,0,4,1, 1,1,1,1,1,0, 6'b011111,0,0));
    vecs.push_back(mk(1,1,0,5,1, 1,1,1,1,1,1, 6'b111111,1,0));
    vecs.push_back(mk(1,1,0,2,3, 1,1,3,1,1,1, 6'b000100,0,0));
    vecs.push_back(mk(1,1,0,0,2, 2,1,3,1,1,1, 6'b000101,0,0));
    vecs.push_back(mk(1,0,0,0,0, 2,1,3,1,1,1, 6'b000101,0,0));

    for (int i = 0; i < vecs.size(); i++) begin
      step(vecs[i], i);
    end

    // Hand-written: 12 sequential words after reset -> two frame pulses,
    // the first right after the 6th word.
    @(negedge clk);
    resetn = 1'b0; in_valid = 1'b0; mode = 1'b0;
    @(negedge clk);
    resetn = 1'b1; mode = 1'b1;
    pulses = 0;
    first_pulse = -1;
    for (int i = 0; i < 12; i++) begin
      in_valid = 1'b1;
      in_data  = TW'(i);
      @(posedge clk);
      #1;
      if (frame_done) begin
        pulses++;
        if (first_pulse < 0) first_pulse = i;
      end
      @(negedge clk);
    end
    in_valid = 1'b0;
    check("seq_pulse_count", 0, 32'(pulses), 32'd2);
    check("seq_first_pulse", 0, 32'(first_pulse), 32'd5);
    check("seq_channels", 0, 32'({z, y, x, w, v, u}),
          32'({3'd3, 3'd2, 3'd1, 3'd0, 3'd7, 3'd6}));
    @(posedge clk);
    #1;
    check("seq_mask_after_done", 0, 32'(wr_mask), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
